mux_scan_n: RTL and testbench

- Parametrised, registered N-channel multiplexer; successor to the 8:1 single-bit gate-level multiplexer.
- Two modes:
  - Manual: external select, registered output.
  - Scan: autonomous round-robin through all channels, holding each channel for a programmable number of cycles.
- Feeds time-multiplexed display/readout paths. Also serves as the generic wide mux for the rest of the design.

---
 rtl/mux_scan_n.sv | 94 +++++++++
 tb/tb_mux_scan_n.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_n.sv
// Registered N-channel multiplexer with a manual select mode and an autonomous
// round-robin scan mode that holds each channel for DWELL enabled cycles.
module mux_scan_n #(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 1,
    parameter int SEL_W    = 3,
    parameter int DWELL    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      enable,
    output logic [WIDTH-1:0]          data_out,
    output logic [SEL_W-1:0]          ch_out,
    output logic                      valid,
    output logic                      wrap
);
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic {
        MANUAL,
        SCAN
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;

    // The channel register doubles as the scan position, so leaving scan
    // naturally discards it and re-entry restarts from channel 0.
    always_comb begin
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        valid_d = 1'b1;
        if (!mode) begin
            ch_d    = sel;
            cnt_d   = '0;
            valid_d = (32'(sel) < CHANNELS);
        end else if (state_q == MANUAL) begin
            ch_d  = '0;
            cnt_d = '0;
        end else if (32'(cnt_q) < DWELL - 1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
            if (32'(ch_q) == CHANNELS - 1) begin
                ch_d   = '0;
                wrap_d = 1'b1;
            end else begin
                ch_d = ch_q + SEL_W'(1);
            end
        end
    end

    // An out-of-range index matches no channel and therefore yields zero.
    always_comb begin
        data_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (ch_d == SEL_W'(k)) begin
                data_d = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MANUAL;
            cnt_q   <= '0;
            ch_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (enable) begin
            state_q <= mode ? SCAN : MANUAL;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign data_out = data_q;
    assign ch_out   = ch_q;
    assign valid    = valid_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Self-checking bench for mux_scan_n: directed scenarios plus randomized traffic,
// compared every cycle against a scan-time model of the multiplexer.
module tb_mux_scan_n;
    localparam int CH = 6;
    localparam int W  = 4;
    localparam int SW = 3;
    localparam int DW = 3;

    logic          clk;
    logic          rst_n;
    logic [CH*W-1:0] dataIn;
    logic [SW-1:0] sel;
    logic          mode;
    logic          enable;
    logic [W-1:0]  dataOut;
    logic [SW-1:0] chOut;
    logic          valid;
    logic          wrap;

    int tests = 0;
    int fails = 0;
    logic checkEn = 1'b0;

    // Model state: in scan, position is just the count of enabled edges since entry.
    logic          mInScan;
    int            mK;
    logic [W-1:0]  eData;
    logic [SW-1:0] eCh;
    logic          eValid;
    logic          eWrap;

    mux_scan_n #(
        .CHANNELS(CH),
        .WIDTH   (W),
        .SEL_W   (SW),
        .DWELL   (DW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (dataIn),
        .sel     (sel),
        .mode    (mode),
        .enable  (enable),
        .data_out(dataOut),
        .ch_out  (chOut),
        .valid   (valid),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] chanOf(int idx);
        return dataIn[idx*W +: W];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mInScan = 1'b0;
            mK      = 0;
            eData   = '0;
            eCh     = '0;
            eValid  = 1'b0;
            eWrap   = 1'b0;
        end else if (enable) begin
            if (!mode) begin
                mInScan = 1'b0;
                eCh     = sel;
                eValid  = (int'(sel) < CH);
                eData   = eValid ? chanOf(int'(sel)) : '0;
                eWrap   = 1'b0;
            end else begin
                if (!mInScan) begin
                    mInScan = 1'b1;
                    mK      = 0;
                end else begin
                    mK++;
                end
                eCh    = SW'((mK / DW) % CH);
                eValid = 1'b1;
                eData  = chanOf((mK / DW) % CH);
                eWrap  = (mK > 0) && (mK % (DW * CH) == 0);
            end
        end
    end

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model data_out", 32'(dataOut), 32'(eData));
            checkOutput("model ch_out", 32'(chOut), 32'(eCh));
            checkOutput("model valid", 32'(valid), 32'(eValid));
            checkOutput("model wrap", 32'(wrap), 32'(eWrap));
        end
    end

    task automatic applyStimulus(logic [SW-1:0] s, logic m, logic en, logic [CH*W-1:0] d);
        sel    = s;
        mode   = m;
        enable = en;
        dataIn = d;
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expectAll(string tag, logic [W-1:0] d, logic [SW-1:0] c, logic v, logic w);
        checkOutput({tag, " data_out"}, 32'(dataOut), 32'(d));
        checkOutput({tag, " ch_out"}, 32'(chOut), 32'(c));
        checkOutput({tag, " valid"}, 32'(valid), 32'(v));
        checkOutput({tag, " wrap"}, 32'(wrap), 32'(w));
    endtask

    initial begin
        rst_n  = 1'b0;
        applyStimulus('0, 1'b0, 1'b0, '0);
        tick(3);
        rst_n   = 1'b1;
        checkEn = 1'b1;
        #1 expectAll("reset", 4'h0, 3'd0, 1'b0, 1'b0);

        // Channels 0..5 = 6, 9, C, 3, A, 5.
        applyStimulus(3'd1, 1'b0, 1'b1, 24'h5A3C96);
        tick(1);
        expectAll("manual sel1", 4'h9, 3'd1, 1'b1, 1'b0);
        applyStimulus(3'd7, 1'b0, 1'b1, 24'h5A3C96);
        tick(1);
        expectAll("manual sel7", 4'h0, 3'd7, 1'b0, 1'b0);
        applyStimulus(3'd5, 1'b0, 1'b1, 24'h5A3C96);
        tick(1);
        expectAll("manual sel5", 4'h5, 3'd5, 1'b1, 1'b0);

        applyStimulus(3'd5, 1'b1, 1'b1, 24'h5A3C96);
        tick(1);
        expectAll("scan entry", 4'h6, 3'd0, 1'b1, 1'b0);
        tick(17);
        expectAll("scan last", 4'h5, 3'd5, 1'b1, 1'b0);
        tick(1);
        expectAll("scan wrap", 4'h6, 3'd0, 1'b1, 1'b1);

        enable = 1'b0;
        tick(10);
        expectAll("freeze", 4'h6, 3'd0, 1'b1, 1'b1);
        enable = 1'b1;
        tick(1);
        expectAll("unfreeze", 4'h6, 3'd0, 1'b1, 1'b0);
        tick(1);
        checkOutput("dwell hold ch_out", 32'(chOut), 32'd0);
        tick(1);
        expectAll("dwell advance", 4'h9, 3'd1, 1'b1, 1'b0);

        applyStimulus(3'd2, 1'b0, 1'b1, 24'h5A3C96);
        tick(1);
        expectAll("back to manual", 4'hC, 3'd2, 1'b1, 1'b0);
        applyStimulus(3'd2, 1'b1, 1'b1, 24'h5A3C96);
        tick(1);
        expectAll("re-entry", 4'h6, 3'd0, 1'b1, 1'b0);
        applyStimulus(3'd2, 1'b1, 1'b1, 24'h5A3C9F);
        tick(1);
        expectAll("live data", 4'hF, 3'd0, 1'b1, 1'b0);
        tick(2);
        checkOutput("re-entry full dwell ch_out", 32'(chOut), 32'd1);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 expectAll("async reset", 4'h0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 600; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) mode = ~mode;
            sel = SW'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) dataIn = 24'($urandom());
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
